// File: rtl/wctl_dvg_stack_if.sv
// Warp-control <-> divergence-stack interface.
// Carries the split/join command from the warp-control unit, the
// stack-pointer query used as the split result, and the registered
// thread-mask/PC update returned to the warp scheduler.
//   master : warp-control / scheduler side (drives commands and query)
//   slave  : divergence stack (drives dvstack_ptr and upd_*)
interface wctl_dvg_stack_if #(
  parameter int NUM_WARPS   = 4,
  parameter int NUM_THREADS = 4,
  parameter int DEPTH       = 4,
  parameter int PC_BITS     = 30
);
  localparam int NW_W = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;
  localparam int SPW  = $clog2(DEPTH + 1);

  logic                   ctl_valid;
  logic [NW_W-1:0]        ctl_wid;
  logic                   split_valid;
  logic                   split_is_dvg;
  logic [NUM_THREADS-1:0] split_then_mask;
  logic [NUM_THREADS-1:0] split_else_mask;
  logic [PC_BITS-1:0]     split_next_pc;
  logic                   join_valid;
  logic [SPW-1:0]         join_stack_ptr;
  logic [NUM_THREADS-1:0] cur_tmask;
  logic [NW_W-1:0]        dvstack_wid;
  logic [SPW-1:0]         dvstack_ptr;
  logic                   upd_valid;
  logic [NW_W-1:0]        upd_wid;
  logic [NUM_THREADS-1:0] upd_tmask;
  logic                   upd_pc_valid;
  logic [PC_BITS-1:0]     upd_pc;

  modport master (
    output ctl_valid, ctl_wid, split_valid, split_is_dvg, split_then_mask,
           split_else_mask, split_next_pc, join_valid, join_stack_ptr,
           cur_tmask, dvstack_wid,
    input  dvstack_ptr, upd_valid, upd_wid, upd_tmask, upd_pc_valid, upd_pc
  );

  modport slave (
    input  ctl_valid, ctl_wid, split_valid, split_is_dvg, split_then_mask,
           split_else_mask, split_next_pc, join_valid, join_stack_ptr,
           cur_tmask, dvstack_wid,
    output dvstack_ptr, upd_valid, upd_wid, upd_tmask, upd_pc_valid, upd_pc
  );
endinterface

// File: rtl/wctl_dvg_stack.sv
// Per-warp divergence (IPDOM) stack for split/join.
// A split pushes {orig_mask, else_mask, else_pc, else_pend} and runs the
// then-mask; the first join of that region switches to the else path, the
// second pops and restores the original mask. Updates are registered and
// appear one cycle after the command as a one-cycle upd_valid pulse.
// Ports:
//   clk, reset  : clock, asynchronous active-high reset
//   bus         : wctl_dvg_stack_if.slave (commands, sp query, updates)
//   err_ovf/udf : sticky overflow/underflow flags
// Build option: WCTL_DVSTACK_CHECK_EN enables overflow/underflow detection;
// without it the flags are tied low and the stack must be sized by software.
module wctl_dvg_stack #(
  parameter int NUM_WARPS   = 4,
  parameter int NUM_THREADS = 4,
  parameter int DEPTH       = 4,
  parameter int PC_BITS     = 30
) (
  input  logic                  clk,
  input  logic                  reset,
  wctl_dvg_stack_if.slave       bus,
  output logic                  err_ovf,
  output logic                  err_udf
);
  localparam int NW_W = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;
  localparam int SPW  = $clog2(DEPTH + 1);
  localparam int IW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [SPW-1:0] SP_FULL = SPW'(DEPTH);
  localparam logic [SPW-1:0] SP_ONE  = SPW'(1);

  logic [SPW-1:0]         sp_q   [NUM_WARPS];
  logic [SPW-1:0]         sp_d   [NUM_WARPS];
  logic [DEPTH-1:0]       pend_q [NUM_WARPS];
  logic [DEPTH-1:0]       pend_d [NUM_WARPS];

  // Entry payload: written on push only, never reset.
  logic [NUM_THREADS-1:0] orig_mask_q [NUM_WARPS][DEPTH];
  logic [NUM_THREADS-1:0] else_mask_q [NUM_WARPS][DEPTH];
  logic [PC_BITS-1:0]     else_pc_q   [NUM_WARPS][DEPTH];

  logic                   upd_valid_q, upd_valid_d;
  logic [NW_W-1:0]        upd_wid_q, upd_wid_d;
  logic [NUM_THREADS-1:0] upd_tmask_q, upd_tmask_d;
  logic                   upd_pc_valid_q, upd_pc_valid_d;
  logic [PC_BITS-1:0]     upd_pc_q, upd_pc_d;
  logic                   push_en;

  logic [NW_W-1:0]        wid;
  logic [SPW-1:0]         sp_w;
  logic [SPW-1:0]         top_w;
  logic [IW-1:0]          top_idx;
  logic [IW-1:0]          push_idx;

  assign wid      = bus.ctl_wid;
  assign sp_w     = sp_q[wid];
  assign top_w    = sp_w - SP_ONE;
  assign top_idx  = top_w[IW-1:0];
  assign push_idx = sp_w[IW-1:0];

`ifdef WCTL_DVSTACK_CHECK_EN
  logic err_ovf_q, err_ovf_d;
  logic err_udf_q, err_udf_d;
`endif

  always_comb begin
    sp_d           = sp_q;
    pend_d         = pend_q;
    push_en        = 1'b0;
    upd_valid_d    = 1'b0;
    upd_pc_valid_d = 1'b0;
    upd_wid_d      = upd_wid_q;
    upd_tmask_d    = upd_tmask_q;
    upd_pc_d       = upd_pc_q;
`ifdef WCTL_DVSTACK_CHECK_EN
    err_ovf_d      = err_ovf_q;
    err_udf_d      = err_udf_q;
`endif
    if (bus.ctl_valid) begin
      upd_wid_d = wid;
      // Split takes priority over a simultaneous (illegal) join.
      if (bus.split_valid) begin
        if (bus.split_is_dvg) begin
          if (sp_w != SP_FULL) begin
            push_en              = 1'b1;
            sp_d[wid]            = sp_w + SP_ONE;
            pend_d[wid][push_idx] = 1'b1;
            upd_valid_d          = 1'b1;
            upd_tmask_d          = bus.split_then_mask;
          end else begin
`ifdef WCTL_DVSTACK_CHECK_EN
            err_ovf_d = 1'b1;
`else
            // Full stack is undefined here; keep sp from wrapping.
            upd_valid_d = 1'b1;
            upd_tmask_d = bus.split_then_mask;
`endif
          end
        end else begin
          upd_valid_d = 1'b1;
          upd_tmask_d = bus.split_then_mask | bus.split_else_mask;
        end
      end else if (bus.join_valid && (bus.join_stack_ptr != sp_w)) begin
        if (sp_w == '0) begin
`ifdef WCTL_DVSTACK_CHECK_EN
          err_udf_d = 1'b1;
`endif
        end else if (pend_q[wid][top_idx]) begin
          pend_d[wid][top_idx] = 1'b0;
          upd_valid_d          = 1'b1;
          upd_tmask_d          = else_mask_q[wid][top_idx];
          upd_pc_valid_d       = 1'b1;
          upd_pc_d             = else_pc_q[wid][top_idx];
        end else begin
          sp_d[wid]   = top_w;
          upd_valid_d = 1'b1;
          upd_tmask_d = orig_mask_q[wid][top_idx];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sp_q           <= '{default: '0};
      pend_q         <= '{default: '0};
      upd_valid_q    <= 1'b0;
      upd_wid_q      <= '0;
      upd_tmask_q    <= '0;
      upd_pc_valid_q <= 1'b0;
      upd_pc_q       <= '0;
    end else begin
      sp_q           <= sp_d;
      pend_q         <= pend_d;
      upd_valid_q    <= upd_valid_d;
      upd_wid_q      <= upd_wid_d;
      upd_tmask_q    <= upd_tmask_d;
      upd_pc_valid_q <= upd_pc_valid_d;
      upd_pc_q       <= upd_pc_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_en) begin
      orig_mask_q[wid][push_idx] <= bus.cur_tmask;
      else_mask_q[wid][push_idx] <= bus.split_else_mask;
      else_pc_q[wid][push_idx]   <= bus.split_next_pc;
    end
  end

`ifdef WCTL_DVSTACK_CHECK_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_ovf_q <= 1'b0;
      err_udf_q <= 1'b0;
    end else begin
      err_ovf_q <= err_ovf_d;
      err_udf_q <= err_udf_d;
    end
  end
  assign err_ovf = err_ovf_q;
  assign err_udf = err_udf_q;
`else
  assign err_ovf = 1'b0;
  assign err_udf = 1'b0;
`endif

  // Pre-update pointer: no bypass, the scheduler stalls the warp meanwhile.
  assign bus.dvstack_ptr  = sp_q[bus.dvstack_wid];
  assign bus.upd_valid    = upd_valid_q;
  assign bus.upd_wid      = upd_wid_q;
  assign bus.upd_tmask    = upd_tmask_q;
  assign bus.upd_pc_valid = upd_pc_valid_q;
  assign bus.upd_pc       = upd_pc_q;
endmodule
